// File: rtl/pipe_sched.sv
// pipe_sched: issue scheduler for fixed-latency compute pipelines.
// Issues one item per cycle while output-buffer credits remain, and tracks
// in-flight items through a LATENCY-deep valid/last shadow pipeline.
// Optional feature: define PIPE_SCHED_ABORT_EN to add the 'abort' input.
`timescale 1ns/1ps

module pipe_sched #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned CREDITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_items,
  input  logic             credit_ret,
`ifdef PIPE_SCHED_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             issue,
  output logic             issue_last,
  output logic             out_valid,
  output logic             out_last,
  output logic             stall,
  output logic             done,
  output logic             cred_err
);

  localparam int unsigned CRED_W = $clog2(CREDITS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CRED_W-1:0]  credits;
  logic [CNT_W-1:0]   remaining;
  logic [LATENCY-1:0] valid_sh;
  logic [LATENCY-1:0] last_sh;
  logic               abort_req;
  logic               drain_empty;
  logic               cred_full;

  assign cred_full = (credits == CRED_W'(CREDITS));

`ifdef PIPE_SCHED_ABORT_EN
  assign abort_req = abort;
  // After an abort there is no last marker, so completion is keyed on the
  // valid shadow emptying: only the oldest slot may still be occupied.
  assign drain_empty = ((valid_sh << 1) == '0);
`else
  assign abort_req = 1'b0;
  assign drain_empty = out_last;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_items == '0) ? DONE : RUN;
      RUN:     if (issue_last || abort_req) state_nxt = DRAIN;
      DRAIN:   if (drain_empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from registered state and counters only
  always_comb begin
    busy       = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    out_valid  = valid_sh[LATENCY-1];
    out_last   = last_sh[LATENCY-1];
    case (state)
      RUN: begin
        busy       = 1'b1;
        issue      = (credits != '0);
        issue_last = issue && (remaining == CNT_W'(1));
        stall      = !issue;
      end
      DRAIN:   busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Items still to issue for the current job
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        remaining <= '0;
    else if (state == IDLE && start) remaining <= num_items;
    else if (issue)                  remaining <= remaining - CNT_W'(1);
  end

  // Credit counter persists across jobs; saturates at CREDITS
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits <= CRED_W'(CREDITS);
    end else begin
      case ({issue, credit_ret})
        2'b10:   credits <= credits - CRED_W'(1);
        2'b01:   if (!cred_full) credits <= credits + CRED_W'(1);
        default: ;
      endcase
    end
  end

  // Sticky over-return flag, cleared by an accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 cred_err <= 1'b0;
    else if (credit_ret && !issue && cred_full) cred_err <= 1'b1;
    else if (state == IDLE && start)          cred_err <= 1'b0;
  end

  // Shadow pipeline mirroring the datapath latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_sh <= '0;
      last_sh  <= '0;
    end else begin
      valid_sh <= LATENCY'({valid_sh, issue});
      last_sh  <= LATENCY'({last_sh, issue_last});
    end
  end

endmodule
